mor1kx_tlb_reload_arbiter: RTL and testbench

- Shares one page-table-walk memory port between the IMMU and DMMU hardware TLB reload engines.
- Grants the port to one MMU for the whole walk, which is pointer fetch plus PTE fetch.
- Routes the owner's address onto the port and routes acks and data back to the owner.
- Sits between both MMUs' tlb_reload_* interfaces and the LSU/bus-side reload port.

---
 rtl/mor1kx_tlb_arb_pkg.sv | 16 +
 rtl/mor1kx_tlb_reload_watchdog.sv | 39 +++
 rtl/mor1kx_tlb_reload_arbiter.sv | 144 ++++++++++++++
 tb/tb_mor1kx_tlb_reload_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_tlb_arb_pkg.sv
// Shared encodings for the IMMU/DMMU TLB reload port arbiter.
package mor1kx_tlb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IMMU = 2'b01;
    localparam logic [1:0] OWNER_DMMU = 2'b10;

    localparam int unsigned TLB_ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mor1kx_tlb_reload_watchdog.sv
// Stall watchdog for the reload port: counts unacked request cycles, pulses expire at the limit.
module mor1kx_tlb_reload_watchdog
    import mor1kx_tlb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TLB_ARB_TIMEOUT_DEFAULT,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stall,
    input  logic ack,
    output logic expire
);

    localparam logic [TIMEOUT_WIDTH-1:0] Limit = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!active || ack) begin
            cnt_d = '0;
        end else if (stall && cnt_q != Limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = active && stall && (cnt_q == Limit);

endmodule

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Arbitrates the shared page-table-walk port between IMMU and DMMU reload engines.
// Optional stall watchdog enabled by MOR1KX_TLB_RELOAD_ARB_TIMEOUT_EN.
module mor1kx_tlb_reload_arbiter
    import mor1kx_tlb_arb_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES       = TLB_ARB_TIMEOUT_DEFAULT,
    parameter int unsigned TIMEOUT_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic                            immu_err_o,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic                            dmmu_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] reload_data_o,
    output logic                            mem_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] mem_addr_o,
    input  logic                            mem_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mem_data_i,
    output logic [1:0]                      owner_o
);

    if ((64'(TIMEOUT_CYCLES) >> TIMEOUT_WIDTH) != 64'd0) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYCLES does not fit in TIMEOUT_WIDTH bits");
    end

    arb_state_e state_q, state_d;
    logic       last_dmmu_q, last_dmmu_d;
    logic       immu_req_eff, dmmu_req_eff;
    logic       expire;

`ifdef MOR1KX_TLB_RELOAD_ARB_TIMEOUT_EN
    logic block_i_q, block_d_q;

    mor1kx_tlb_reload_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (state_q != ARB_IDLE),
        .stall  (mem_req_o && !mem_ack_i),
        .ack    (mem_ack_i),
        .expire (expire)
    );

    // A timed-out requester must drop req once before it can compete again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_i_q <= 1'b0;
            block_d_q <= 1'b0;
        end else begin
            block_i_q <= block_i_q ? immu_req_i : (expire && state_q == ARB_GRANT_I);
            block_d_q <= block_d_q ? dmmu_req_i : (expire && state_q == ARB_GRANT_D);
        end
    end

    assign immu_req_eff = immu_req_i && !block_i_q;
    assign dmmu_req_eff = dmmu_req_i && !block_d_q;
    assign immu_err_o   = expire && (state_q == ARB_GRANT_I);
    assign dmmu_err_o   = expire && (state_q == ARB_GRANT_D);
`else
    assign immu_req_eff = immu_req_i;
    assign dmmu_req_eff = dmmu_req_i;
    assign expire       = 1'b0;
    assign immu_err_o   = 1'b0;
    assign dmmu_err_o   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_dmmu_d = last_dmmu_q;
        case (state_q)
            ARB_IDLE: begin
                if (immu_req_eff && dmmu_req_eff) begin
                    state_d = last_dmmu_q ? ARB_GRANT_I : ARB_GRANT_D;
                end else if (immu_req_eff) begin
                    state_d = ARB_GRANT_I;
                end else if (dmmu_req_eff) begin
                    state_d = ARB_GRANT_D;
                end
            end
            ARB_GRANT_I: begin
                if (!immu_req_i) begin
                    last_dmmu_d = 1'b0;
                    state_d     = dmmu_req_eff ? ARB_GRANT_D : ARB_IDLE;
                end
            end
            ARB_GRANT_D: begin
                if (!dmmu_req_i) begin
                    last_dmmu_d = 1'b1;
                    state_d     = immu_req_eff ? ARB_GRANT_I : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (expire) begin
            state_d     = ARB_IDLE;
            last_dmmu_d = (state_q == ARB_GRANT_D);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            last_dmmu_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_dmmu_q <= last_dmmu_d;
        end
    end

    always_comb begin
        owner_o    = OWNER_NONE;
        mem_addr_o = '0;
        mem_req_o  = 1'b0;
        immu_ack_o = 1'b0;
        dmmu_ack_o = 1'b0;
        case (state_q)
            ARB_GRANT_I: begin
                owner_o    = OWNER_IMMU;
                mem_addr_o = immu_addr_i;
                mem_req_o  = immu_req_i;
                immu_ack_o = mem_ack_i && immu_req_i;
            end
            ARB_GRANT_D: begin
                owner_o    = OWNER_DMMU;
                mem_addr_o = dmmu_addr_i;
                mem_req_o  = dmmu_req_i;
                dmmu_ack_o = mem_ack_i && dmmu_req_i;
            end
            default: ;
        endcase
    end

    // Data is held at zero while reset is asserted so every output reads 0.
    assign reload_data_o = rst ? '0 : mem_data_i;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Directed self-checking bench for mor1kx_tlb_reload_arbiter.
module tb_mor1kx_tlb_reload_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        immu_req, dmmu_req, mem_ack;
    logic [31:0] immu_addr, dmmu_addr, mem_data;
    logic        immu_ack, immu_err, dmmu_ack, dmmu_err, mem_req;
    logic [31:0] reload_data, mem_addr;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mor1kx_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH (32),
        .TIMEOUT_CYCLES       (4),
        .TIMEOUT_WIDTH        (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .immu_req_i    (immu_req),
        .immu_addr_i   (immu_addr),
        .immu_ack_o    (immu_ack),
        .immu_err_o    (immu_err),
        .dmmu_req_i    (dmmu_req),
        .dmmu_addr_i   (dmmu_addr),
        .dmmu_ack_o    (dmmu_ack),
        .dmmu_err_o    (dmmu_err),
        .reload_data_o (reload_data),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_data_i    (mem_data),
        .owner_o       (owner)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        immu_req  = 1'b0;
        dmmu_req  = 1'b0;
        mem_ack   = 1'b0;
        immu_addr = '0;
        dmmu_addr = '0;
        mem_data  = '0;
        settle();
        check_eq("rst_owner", owner, 2'b00);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_acks", {immu_ack, dmmu_ack}, 2'b00);
        check_eq("rst_errs", {immu_err, dmmu_err}, 2'b00);
        tick();
        rst = 1'b0;

        // Single IMMU walk, ack three cycles after grant
        immu_req  = 1'b1;
        immu_addr = 32'h1000;
        settle();
        check_eq("t1_pre_owner", owner, 2'b00);
        check_eq("t1_pre_req", mem_req, 1'b0);
        tick();
        check_eq("t1_owner", owner, 2'b01);
        check_eq("t1_mem_req", mem_req, 1'b1);
        check_eq("t1_addr", mem_addr, 32'h1000);
        tick();
        tick();
        check_eq("t1_no_ack", {immu_ack, dmmu_ack}, 2'b00);
        mem_ack  = 1'b1;
        mem_data = 32'hCAFE0400;
        settle();
        check_eq("t1_iack", immu_ack, 1'b1);
        check_eq("t1_dack", dmmu_ack, 1'b0);
        check_eq("t1_data", reload_data, 32'hCAFE0400);
        tick();
        mem_ack  = 1'b0;
        immu_req = 1'b0;
        settle();
        check_eq("t1_rel_req", mem_req, 1'b0);
        tick();
        check_eq("t1_idle", owner, 2'b00);

        // Tie after reset goes to IMMU, then zero-cycle handoff to DMMU
        do_reset();
        immu_req  = 1'b1;
        dmmu_req  = 1'b1;
        immu_addr = 32'h1100;
        dmmu_addr = 32'h2200;
        tick();
        check_eq("tie1_owner", owner, 2'b01);
        check_eq("tie1_addr", mem_addr, 32'h1100);
        immu_req = 1'b0;
        tick();
        check_eq("handoff_owner", owner, 2'b10);
        check_eq("handoff_addr", mem_addr, 32'h2200);
        check_eq("handoff_req", mem_req, 1'b1);
        dmmu_req = 1'b0;
        tick();
        check_eq("tie_idle1", owner, 2'b00);
        immu_req = 1'b1;
        dmmu_req = 1'b1;
        tick();
        check_eq("tie2_owner", owner, 2'b01);
        immu_req = 1'b0;
        dmmu_req = 1'b0;
        tick();
        check_eq("tie_idle2", owner, 2'b00);
        immu_req = 1'b1;
        dmmu_req = 1'b1;
        tick();
        check_eq("tie3_owner", owner, 2'b10);
        immu_req = 1'b0;
        dmmu_req = 1'b0;
        tick();

        // DMMU two-access walk with IMMU waiting
        dmmu_req  = 1'b1;
        dmmu_addr = 32'h2000;
        tick();
        check_eq("dw_owner", owner, 2'b10);
        check_eq("dw_addr1", mem_addr, 32'h2000);
        mem_ack = 1'b1;
        settle();
        check_eq("dw_dack1", dmmu_ack, 1'b1);
        check_eq("dw_iack1", immu_ack, 1'b0);
        tick();
        mem_ack   = 1'b0;
        dmmu_addr = 32'h3004;
        immu_req  = 1'b1;
        settle();
        check_eq("dw_addr2", mem_addr, 32'h3004);
        tick();
        check_eq("dw_hold", owner, 2'b10);
        mem_ack = 1'b1;
        settle();
        check_eq("dw_dack2", dmmu_ack, 1'b1);
        check_eq("dw_iack2", immu_ack, 1'b0);
        tick();
        dmmu_req = 1'b0;
        settle();
        check_eq("late_ack", {immu_ack, dmmu_ack}, 2'b00);
        mem_ack = 1'b0;
        tick();
        check_eq("dw_to_immu", owner, 2'b01);
        immu_req = 1'b0;
        tick();

        // Stray ack in IDLE
        mem_ack = 1'b1;
        settle();
        check_eq("stray_acks", {immu_ack, dmmu_ack}, 2'b00);
        tick();
        check_eq("stray_state", owner, 2'b00);
        mem_ack = 1'b0;

        // Async reset mid-grant
        dmmu_req = 1'b1;
        tick();
        check_eq("ar_pre_owner", owner, 2'b10);
        #3;
        rst = 1'b1;
        #1;
        check_eq("ar_mem_req", mem_req, 1'b0);
        check_eq("ar_owner", owner, 2'b00);
        #2;
        rst = 1'b0;
        tick();
        check_eq("ar_regrant", owner, 2'b10);
        check_eq("ar_regrant_req", mem_req, 1'b1);
        dmmu_req = 1'b0;
        tick();

`ifdef MOR1KX_TLB_RELOAD_ARB_TIMEOUT_EN
        do_reset();
        immu_req  = 1'b1;
        immu_addr = 32'h4000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("to_no_err", immu_err, 1'b0);
        end
        tick();
        check_eq("to_err", immu_err, 1'b1);
        check_eq("to_derr", dmmu_err, 1'b0);
        tick();
        check_eq("to_err_once", immu_err, 1'b0);
        check_eq("to_idle", owner, 2'b00);
        tick();
        check_eq("to_blocked", owner, 2'b00);
        immu_req = 1'b0;
        tick();
        immu_req = 1'b1;
        tick();
        check_eq("to_regrant", owner, 2'b01);
        immu_req = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
